// File: rtl/spi_pwm_cfg_pkg.sv
// Shared constants and types for the SPI-slave PWM configuration controller.
// Holds the frame width, the bit-counter width, the register address map and the FSM state encoding.
// Imported by spi_pwm_cfg_ctrl and sync_edge; contains no logic.
package spi_pwm_cfg_pkg;

    localparam int FRAME_W = 16;   // R/W + 7-bit address + 8-bit data
    localparam int CNT_W   = 5;    // must count 0..FRAME_W inclusive

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_pwm_cfg_ctrl_sync_edge.sv
// Synchroniser for one asynchronous input with rise/fall pulse detection.
// Ports: clk_i/rst_n_i (clock, async active-low reset), async_i (raw pin),
//        level_o (synced level), rise_o/fall_o (one-clk pulses, combinational from the last two flops).
// Latency: SYNC_STAGES clks to level_o; pulses are valid in the clk after level_o changes. No backpressure.
module sync_edge
    import spi_pwm_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Chain resets to 0 so that an input already low at reset release (e.g. ncs held
    // low) produces no falling-edge pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI-slave (mode 0, 16-bit MSB-first frames) that writes the five PWM configuration registers.
// Ports: clk/rst_n system side; sclk/copi/ncs async SPI inputs; cipo readback data; five 8-bit register
//        outputs; cfg_update one-clk pulse per committed write. Latency: write lands SYNC_STAGES+1 clks
//        after ncs rises. No backpressure. Optional readback enabled by defining SPI_READBACK_EN.
module spi_pwm_cfg_ctrl
    import spi_pwm_cfg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       cfg_update
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk), .rst_n_i(rst_n_s), .async_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk_i(clk), .rst_n_i(rst_n_s), .async_i(copi),
        .level_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk_i(clk), .rst_n_i(rst_n_s), .async_i(ncs),
        .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    // Synchroniser outputs this build does not consume.
    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic [7:0]         regs_q [NUM_REGS];
    logic               cfg_update_q;
    logic               addr_ok;

    // Frame layout once all 16 bits are in: [15]=R/W, [14:8]=address, [7:0]=data.
    assign addr_ok = ({25'd0, shift_q[14:8]} < NUM_REGS);

`ifdef SPI_READBACK_EN
    logic [7:0] rd_buf_q;
    logic       rd_act_q;
    logic       cipo_q;
    logic [6:0] rd_addr;
    logic [7:0] rd_mux;

    // On the 8th rise shift_q holds {R/W, addr[6:1]} in bits 6:0 and copi_s is addr[0].
    assign rd_addr = {shift_q[5:0], copi_s};

    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == i[6:0]) begin
                rd_mux = regs_q[i];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            cfg_update_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
`ifdef SPI_READBACK_EN
            rd_buf_q <= 8'h00;
            rd_act_q <= 1'b0;
            cipo_q   <= 1'b0;
`endif
        end else begin
            cfg_update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end

                SHIFT: begin
                    if (ncs_rise) begin
                        // Short frame: discard without touching the registers.
                        state_q <= IDLE;
`ifdef SPI_READBACK_EN
                        rd_act_q <= 1'b0;
                        cipo_q   <= 1'b0;
`endif
                    end else begin
                        if (sclk_rise) begin
                            shift_q   <= {shift_q[FRAME_W-2:0], copi_s};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= DONE;
                            end
`ifdef SPI_READBACK_EN
                            // 8th rise with R/W=0: present the read data MSB straight away.
                            if (bit_cnt_q == 5'd7 && !shift_q[6]) begin
                                rd_buf_q <= rd_mux;
                                cipo_q   <= rd_mux[7];
                                rd_act_q <= 1'b1;
                            end
`endif
                        end
`ifdef SPI_READBACK_EN
                        // The fall right after the 8th rise keeps bit 7 for the 9th rise;
                        // later falls advance one bit each.
                        else if (sclk_fall && rd_act_q && (bit_cnt_q >= 5'd9)) begin
                            rd_buf_q <= {rd_buf_q[6:0], 1'b0};
                            cipo_q   <= rd_buf_q[6];
                        end
`endif
                    end
                end

                DONE: begin
                    // Extra sclk edges are ignored; only ncs rising matters here.
                    if (ncs_rise) begin
                        state_q <= IDLE;
                        if (shift_q[15] && addr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (shift_q[14:8] == i[6:0]) begin
                                    regs_q[i] <= shift_q[7:0];
                                end
                            end
                            cfg_update_q <= 1'b1;
                        end
`ifdef SPI_READBACK_EN
                        rd_act_q <= 1'b0;
                        cipo_q   <= 1'b0;
`endif
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY];
    assign cfg_update      = cfg_update_q;

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// Bench for spi_pwm_cfg_ctrl: directed frames plus a randomized frame loop against a register-map model.
// Drives SPI with 5-clk half periods, samples outputs #1 after clock edges or on negedges.
// Readback checks are compiled in when SPI_READBACK_EN is defined.
module tb_spi_pwm_cfg_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic       cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       cfg_update;

    always #5 clk = ~clk;

    spi_pwm_cfg_ctrl #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .cfg_update(cfg_update)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the register map as a plain array.
    logic [7:0] m_regs [5];

    // Monitors (only these processes write their variables).
    int          pulses      = 0;
    int          last_lat    = 0;
    int          cipo_hi_cnt = 0;
    int          since_rise  = 0;
    logic [39:0] pulse_snap  = '0;

    function automatic logic [39:0] outs();
        return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
    endfunction

    function automatic logic [39:0] m_outs();
        return {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4]};
    endfunction

    always @(posedge clk) since_rise <= ncs ? since_rise + 1 : 0;

    always @(negedge clk) begin
        if (cfg_update === 1'b1) begin
            pulses     = pulses + 1;
            last_lat   = since_rise;
            pulse_snap = outs();
        end
        if (cipo === 1'b1) cipo_hi_cnt = cipo_hi_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI transaction of nbits clocks; bits past 16 are random. rd collects cipo before rises 9..16.
    task automatic spi_xfer(input logic [15:0] w, input int nbits, output logic [7:0] rd);
        rd  = 8'h00;
        ncs = 1'b0;
        clks(6);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? w[15-i] : 1'($urandom_range(0, 1));
            clks(5);
            if (i >= 8 && i < 16) rd = {rd[6:0], cipo};
            sclk = 1'b1;
            clks(5);
            sclk = 1'b0;
        end
        clks(5);
        ncs = 1'b1;
        clks(12);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    endtask

    // Runs one frame, updates the model from the frame rules and checks the outcome.
    // fresh=0 means the bench knows no ncs falling edge will be seen for this frame.
    task automatic run_frame(input logic [15:0] w, input int nbits, input bit fresh, input string tag);
        int         p0, h0, a;
        logic [7:0] rd, exp_rd;
        bit         exp_wr;
        p0     = pulses;
        h0     = cipo_hi_cnt;
        a      = int'(w[14:8]);
        exp_wr = fresh && (nbits >= 16) && w[15] && (a < 5);
        exp_rd = (a < 5) ? m_regs[a] : 8'h00;
        spi_xfer(w, nbits, rd);
        if (exp_wr) m_regs[a] = w[7:0];
        check({tag, ":regs"}, outs(), m_outs());
        check({tag, ":pulses"}, pulses - p0, exp_wr ? 1 : 0);
        check({tag, ":cipo_end"}, cipo, 1'b0);
        if (exp_wr) begin
            check({tag, ":latency"}, last_lat, 3);
            check({tag, ":same_clk"}, pulse_snap, m_outs());
        end
`ifdef SPI_READBACK_EN
        if (fresh && nbits >= 16 && !w[15]) check({tag, ":readback"}, rd, exp_rd);
`else
        check({tag, ":cipo_quiet"}, cipo_hi_cnt - h0, 0);
`endif
    endtask

    initial begin
        logic [15:0] w;
        int          nb, sel;
        clear_model();

        // Reset state.
        #2 rst_n = 1'b0;
        clks(3);
        check("reset:regs", outs(), 40'h0);
        check("reset:cfg_update", cfg_update, 1'b0);
        check("reset:cipo", cipo, 1'b0);
        rst_n = 1'b1;
        clks(4);

        run_frame(16'h80F0, 16, 1'b1, "wr_out_lo");
        run_frame(16'h8480, 16, 1'b1, "wr_duty");
        run_frame(16'h85AA, 16, 1'b1, "wr_bad_addr");
        run_frame(16'h82FF, 10, 1'b1, "abort10");
        run_frame(16'h8255, 16, 1'b1, "wr_pwm_lo");
        run_frame(16'h813C, 20, 1'b1, "overlong");
        run_frame(16'h0400, 16, 1'b1, "rd_duty");
        run_frame(16'hFF12, 16, 1'b1, "wr_addr7f");
        run_frame(16'h7F00, 16, 1'b1, "rd_addr7f");

        // Reset while idle.
        rst_n = 1'b0;
        clks(2);
        clear_model();
        check("idle_reset:regs", outs(), 40'h0);
        rst_n = 1'b1;
        clks(4);

        // ncs held low through reset release: that frame must not start.
        ncs   = 1'b0;
        rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(4);
        run_frame(16'h8377, 16, 1'b0, "cs_low_at_release");
        run_frame(16'h8366, 16, 1'b1, "after_cs_low");

        // Reset in the middle of a write frame.
        ncs = 1'b0;
        clks(6);
        w = 16'h84EE;
        for (int i = 0; i < 8; i++) begin
            copi = w[15-i];
            clks(5);
            sclk = 1'b1;
            clks(5);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        clks(2);
        clear_model();
        check("midframe_reset:regs", outs(), 40'h0);
        rst_n = 1'b1;
        clks(4);
        ncs = 1'b1;
        clks(12);
        check("midframe_reset:after", outs(), 40'h0);
        run_frame(16'h8101, 16, 1'b1, "after_mid_reset");

        // Randomized frames.
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 19));
            w[15]   = ($urandom_range(0, 3) != 0);
            w[14:8] = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            w[7:0]  = 8'($urandom);
            if (sel < 3)      nb = int'($urandom_range(1, 15));
            else if (sel < 6) nb = int'($urandom_range(17, 20));
            else              nb = 16;
            run_frame(w, nb, 1'b1, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
